// File: rtl/request_conditioner_pkg.sv
// Shared defaults and the per-line bundle type for the traffic_light input front-end.
// Line order in every 5-bit bundle, MSB first: A, B, R, AT, BT.
package request_conditioner_pkg;

    localparam int DB_CYCLES_DEF   = 4;
    localparam int CW_DEF          = 3;
    localparam int HOLD_CYCLES_DEF = 40;
    localparam int HW_DEF          = 8;
    localparam int NUM_LINES       = 5;

    typedef struct packed {
        logic a;
        logic b;
        logic r;
        logic at;
        logic bt;
    } line_vec_t;

endpackage

// File: rtl/request_conditioner_debounce_ch.sv
// One input line: 2-FF synchroniser then a debouncer that accepts a new level after DB_CYCLES
// consecutive disagreeing synced samples; level changes DB_CYCLES+2 edges after a clean raw edge.
module debounce_ch
    import request_conditioner_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic          s1_q, s2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        rise  = 1'b0;
        fall  = 1'b0;
        if (s2_q != db_q) begin
            // A single agreeing sample drops back into the default cnt_d = 0 (bounce restart).
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                db_d = s2_q;
                rise = s2_q;
                fall = ~s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= raw;
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign level = db_q;

endmodule

// File: rtl/request_conditioner.sv
// Conditions raw panel/sensor lines for traffic_light: debounce, A/B minimum hold, R > A > B priority.
// Outputs are combinational from registers; DB_CYCLES+2 edges from raw to output, no backpressure.
module request_conditioner
    import request_conditioner_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int CW          = CW_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int HW          = HW_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic A_raw,
    input  logic B_raw,
    input  logic R_raw,
    input  logic AT_raw,
    input  logic BT_raw,
    output logic A,
    output logic B,
    output logic R,
    output logic AT,
    output logic BT,
    output logic A_rise,
    output logic B_rise
);

    logic [NUM_LINES-1:0] raw_vec, lvl_vec, rise_vec, fall_vec;
    line_vec_t            lvl, rise_ev;
    logic [7:0]           unused_ev;

    logic [HW-1:0] hold_a_q, hold_a_d, hold_b_q, hold_b_d;
    logic          held_a, held_b;
    logic          a_q, b_q;

    assign raw_vec = {A_raw, B_raw, R_raw, AT_raw, BT_raw};

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_ch
        debounce_ch #(
            .DB_CYCLES (DB_CYCLES),
            .CW        (CW)
        ) u_ch (
            .CLK   (CLK),
            .RST   (RST),
            .raw   (raw_vec[i]),
            .level (lvl_vec[i]),
            .rise  (rise_vec[i]),
            .fall  (fall_vec[i])
        );
    end

    assign lvl       = lvl_vec;
    assign rise_ev   = rise_vec;
    assign unused_ev = {rise_ev.r, rise_ev.at, rise_ev.bt, fall_vec};

    // A fresh accepted rise reloads the full hold even if one is already running.
    always_comb begin
        hold_a_d = hold_a_q;
        hold_b_d = hold_b_q;
        if (rise_ev.a)
            hold_a_d = HW'(HOLD_CYCLES);
        else if (hold_a_q != '0)
            hold_a_d = hold_a_q - 1'b1;
        if (rise_ev.b)
            hold_b_d = HW'(HOLD_CYCLES);
        else if (hold_b_q != '0)
            hold_b_d = hold_b_q - 1'b1;
    end

    assign held_a = lvl.a | (hold_a_q != '0);
    assign held_b = lvl.b | (hold_b_q != '0);

    assign R  = lvl.r;
    assign A  = held_a & ~lvl.r;
    assign B  = held_b & ~held_a & ~lvl.r;
    assign AT = lvl.at;
    assign BT = lvl.bt;

    assign A_rise = A & ~a_q;
    assign B_rise = B & ~b_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_a_q <= '0;
            hold_b_q <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
        end else begin
            hold_a_q <= hold_a_d;
            hold_b_q <= hold_b_d;
            a_q      <= A;
            b_q      <= B;
        end
    end

endmodule
